// File: rtl/result_bcd_display.sv
// Display stage: captures an 8-bit result, converts it to three BCD digits with a
// bit-serial double-dabble engine, and drives three active-low 7-segment digits.
module result_bcd_display #(
  parameter bit LEAD_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  result,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [6:0]  seg_hund,
  output logic [6:0]  seg_tens,
  output logic [6:0]  seg_ones
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SCR_W  = 10;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CNT_W  = 3;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_LEAD_RST = LEAD_BLANK ? SEG_BLANK : SEG_ZERO;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t             state, state_next;
  logic [DATA_W-1:0]  shreg, shreg_next;
  logic [SCR_W-1:0]   scratch, scratch_next;
  logic [SCR_W-1:0]   scr_adj;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               busy_next, done_next;
  logic [BCD_W-1:0]   bcd_next;
  logic [SEG_W-1:0]   seg_hund_next, seg_tens_next, seg_ones_next;
  logic               hund_blank, tens_blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction

  function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Hundreds never exceeds 2, so only the tens and ones nibbles need the +3 correction.
  always_comb begin
    scr_adj = {scratch[9:8], add3(scratch[7:4]), add3(scratch[3:0])};
  end

  always_comb begin
    hund_blank = LEAD_BLANK && (scratch[9:8] == 2'd0);
    tens_blank = hund_blank && (scratch[7:4] == 4'd0);
  end

  // Next-state and datapath/output update.
  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    scratch_next  = scratch;
    cnt_next      = cnt;
    busy_next     = busy;
    done_next     = 1'b0;
    bcd_next      = bcd;
    seg_hund_next = seg_hund;
    seg_tens_next = seg_tens;
    seg_ones_next = seg_ones;

    case (state)
      S_IDLE: begin
        busy_next = 1'b0;
        if (load) begin
          shreg_next   = result;
          scratch_next = '0;
          cnt_next     = '0;
          busy_next    = 1'b1;
          state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy_next                   = 1'b1;
        {scratch_next, shreg_next}  = {scr_adj[SCR_W-2:0], shreg, 1'b0};
        cnt_next                    = cnt + 3'd1;
        if (cnt == CNT_LAST) begin
          state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        bcd_next      = {2'b00, scratch};
        seg_hund_next = hund_blank ? SEG_BLANK : seg7({2'b00, scratch[9:8]});
        seg_tens_next = tens_blank ? SEG_BLANK : seg7(scratch[7:4]);
        seg_ones_next = seg7(scratch[3:0]);
        done_next     = 1'b1;
        busy_next     = 1'b0;
        state_next    = S_IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      seg_hund <= SEG_LEAD_RST;
      seg_tens <= SEG_LEAD_RST;
      seg_ones <= SEG_ZERO;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      scratch  <= scratch_next;
      cnt      <= cnt_next;
      busy     <= busy_next;
      done     <= done_next;
      bcd      <= bcd_next;
      seg_hund <= seg_hund_next;
      seg_tens <= seg_tens_next;
      seg_ones <= seg_ones_next;
    end
  end

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display: blanking and non-blanking instances side by side.
module tb_result_bcd_display;

  logic        clk, rst, load;
  logic [7:0]  result;
  logic        busy, done, busy0, done0;
  logic [11:0] bcd, bcd0;
  logic [6:0]  seg_hund, seg_tens, seg_ones;
  logic [6:0]  seg_hund0, seg_tens0, seg_ones0;

  int checks = 0;
  int errors = 0;

  result_bcd_display #(.LEAD_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .result(result), .load(load),
    .busy(busy), .done(done), .bcd(bcd),
    .seg_hund(seg_hund), .seg_tens(seg_tens), .seg_ones(seg_ones)
  );

  result_bcd_display #(.LEAD_BLANK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .result(result), .load(load),
    .busy(busy0), .done(done0), .bcd(bcd0),
    .seg_hund(seg_hund0), .seg_tens(seg_tens0), .seg_ones(seg_ones0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  val;
    logic [11:0] e_bcd;
    logic [6:0]  e_hund, e_tens, e_ones;   // LEAD_BLANK=1
    logic [6:0]  e_hund0, e_tens0;         // LEAD_BLANK=0
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " bcd"}, 32'(bcd), 32'h000);
    chk({tag, " hund"}, 32'(seg_hund), 32'h7F);
    chk({tag, " tens"}, 32'(seg_tens), 32'h7F);
    chk({tag, " ones"}, 32'(seg_ones), 32'h40);
    chk({tag, " hund0"}, 32'(seg_hund0), 32'h40);
    chk({tag, " tens0"}, 32'(seg_tens0), 32'h40);
    chk({tag, " ones0"}, 32'(seg_ones0), 32'h40);
  endtask

  // Load strobe sampled at E0; busy must rise and any previous done must clear.
  task automatic do_load(input logic [7:0] v, input string tag);
    @(negedge clk);
    result = v;
    load   = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    chk({tag, " busy@E0"}, 32'(busy), 32'd1);
    chk({tag, " done@E0"}, 32'(done), 32'd0);
  endtask

  // Count edges until done; outputs must hold and busy stay high meanwhile.
  task automatic wait_done(input int n, input string tag);
    int k = 0;
    logic hold_ok = 1'b1;
    logic busy_ok = 1'b1;
    logic [11:0] b_prev = bcd;
    logic [6:0]  s_prev = seg_ones;
    while (k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (done) break;
      if (bcd !== b_prev || seg_ones !== s_prev) hold_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      result = 8'(result + 8'd37);
    end
    chk({tag, " latency"}, 32'(k), 32'(n));
    chk({tag, " hold"}, 32'(hold_ok), 32'd1);
    chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_digits(input vec_t v, input string tag);
    chk({tag, " bcd"}, 32'(bcd), 32'(v.e_bcd));
    chk({tag, " hund"}, 32'(seg_hund), 32'(v.e_hund));
    chk({tag, " tens"}, 32'(seg_tens), 32'(v.e_tens));
    chk({tag, " ones"}, 32'(seg_ones), 32'(v.e_ones));
    chk({tag, " bcd0"}, 32'(bcd0), 32'(v.e_bcd));
    chk({tag, " hund0"}, 32'(seg_hund0), 32'(v.e_hund0));
    chk({tag, " tens0"}, 32'(seg_tens0), 32'(v.e_tens0));
    chk({tag, " ones0"}, 32'(seg_ones0), 32'(v.e_ones));
  endtask

  initial begin
    //          val     bcd      hund     tens     ones     hund0    tens0
    vecs[0] = '{8'd255, 12'h255, 7'h24, 7'h12, 7'h12, 7'h24, 7'h12};
    vecs[1] = '{8'd7,   12'h007, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40};
    vecs[2] = '{8'd100, 12'h100, 7'h79, 7'h40, 7'h40, 7'h79, 7'h40};
    vecs[3] = '{8'd0,   12'h000, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40};
    vecs[4] = '{8'd58,  12'h058, 7'h7F, 7'h12, 7'h00, 7'h40, 7'h12};
    vecs[5] = '{8'd160, 12'h160, 7'h79, 7'h02, 7'h40, 7'h79, 7'h02};
    vecs[6] = '{8'd13,  12'h013, 7'h7F, 7'h79, 7'h30, 7'h40, 7'h79};
    vecs[7] = '{8'd99,  12'h099, 7'h7F, 7'h10, 7'h10, 7'h40, 7'h10};

    rst = 1'b1; load = 1'b0; result = 8'd0;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].val, $sformatf("v%0d", vecs[i].val));
      wait_done(9, $sformatf("v%0d", vecs[i].val));
      chk_digits(vecs[i], $sformatf("v%0d", vecs[i].val));
    end

    // Load while busy is ignored.
    do_load(8'd42, "busy_load");
    repeat (3) @(negedge clk);
    result = 8'd99;
    load   = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("busy_load busy@E3", 32'(busy), 32'd1);
    wait_done(6, "busy_load");
    chk("busy_load bcd", 32'(bcd), 32'h042);
    chk("busy_load tens", 32'(seg_tens), 32'h19);
    chk("busy_load ones", 32'(seg_ones), 32'h24);

    // Load issued in the done cycle is accepted.
    do_load(8'd99, "done_load");
    wait_done(9, "done_load");
    chk("done_load bcd", 32'(bcd), 32'h099);

    // Reset mid-conversion.
    do_load(8'd200, "midrst");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    begin
      logic saw_done = 1'b0;
      repeat (12) begin
        @(posedge clk);
        #1;
        if (done) saw_done = 1'b1;
      end
      chk("midrst no_done", 32'(saw_done), 32'd0);
      chk("midrst bcd_kept", 32'(bcd), 32'h000);
    end
    do_load(8'd13, "after_rst");
    wait_done(9, "after_rst");
    chk_digits(vecs[6], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
